// File: rtl/obj_line_scheduler_pkg.sv
// ============================================================================
// Module      : obj_line_scheduler_pkg
// Description : Shared OBM layout, object limits and scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package obj_line_scheduler_pkg;

    localparam int NUM_OBJECTS = 64;
    localparam int MAX_SLOTS   = 8;
    localparam int OBJ_HEIGHT  = 8;

    localparam logic [1:0] OBM_OFS_COLOR = 2'd0;
    localparam logic [1:0] OBM_OFS_ATTR  = 2'd1;
    localparam logic [1:0] OBM_OFS_Y     = 2'd2;
    localparam logic [1:0] OBM_OFS_X     = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_ATTR  = 3'd2,
        ST_XPOS  = 3'd3,
        ST_COLOR = 3'd4,
        ST_DONE  = 3'd5
    } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/obj_line_scheduler_y_hit.sv
// ============================================================================
// Module      : obj_y_hit_m
// Description : Combinational object/line coverage test and pattern row select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module obj_y_hit_m
    import obj_line_scheduler_pkg::*;
(
    input  logic [7:0] line_i,
    input  logic [7:0] y_i,
    input  logic       vflip_i,
    output logic       hit_o,
    output logic [2:0] row_o
);

    logic [7:0] diff;

    // Modulo-256 difference lets objects near the bottom wrap onto the top lines.
    assign diff  = line_i - y_i;
    assign hit_o = (diff < 8'(OBJ_HEIGHT));
    assign row_o = vflip_i ? (3'd7 - diff[2:0]) : diff[2:0];

endmodule

`default_nettype wire

// File: rtl/obj_line_scheduler.sv
// ============================================================================
// Module      : obj_line_scheduler
// Description : Scans OBM for one scanline and emits up to 8 object slot writes.
//               Optional overflow detection: define OBJ_SCHED_OVERFLOW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module obj_line_scheduler
    import obj_line_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] next_y_i,
    output logic       obm_rd_o,
    output logic [7:0] obm_addr_o,
    input  logic [7:0] obm_data_i,
    output logic       slot_wr_o,
    output logic [2:0] slot_idx_o,
    output logic [7:0] slot_xp_o,
    output logic [4:0] slot_pmfa_o,
    output logic       slot_hflip_o,
    output logic [2:0] slot_row_o,
    output logic [2:0] slot_color_o,
    output logic [3:0] slot_count_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       overflow_o
);

    sched_state_e state_q, state_d;
    logic [6:0]   scan_idx_q, scan_idx_d;
    logic [7:0]   line_q, line_d;
    logic [3:0]   slot_count_q, slot_count_d;
    logic         test_vld_q, test_vld_d;
    logic [5:0]   obj_q, obj_d;
    logic [7:0]   hit_y_q, hit_y_d;
    logic [7:0]   xp_q, xp_d;
    logic [4:0]   pmfa_q, pmfa_d;
    logic         hflip_q, hflip_d;
    logic [2:0]   row_q, row_d;

    logic         hit;
    logic [2:0]   row;
    logic         slots_full;
    logic         last_slot;
    logic         more_y;
    logic [5:0]   test_obj;

    // One checker serves both the Y test in SCAN and the row resolve in ATTR.
    obj_y_hit_m u_y_hit (
        .line_i  (line_q),
        .y_i     ((state_q == ST_ATTR) ? hit_y_q : obm_data_i),
        .vflip_i (obm_data_i[5]),
        .hit_o   (hit),
        .row_o   (row)
    );

    assign slots_full = (slot_count_q == 4'(MAX_SLOTS));
    assign more_y     = (scan_idx_q < 7'(NUM_OBJECTS));
    assign test_obj   = 6'(scan_idx_q - 7'd1);

`ifdef OBJ_SCHED_OVERFLOW_EN
    logic ovf_q, ovf_d;
    assign last_slot  = 1'b0;
    assign overflow_o = ovf_q;
`else
    assign last_slot  = (slot_count_q == 4'(MAX_SLOTS - 1));
    assign overflow_o = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        scan_idx_d   = scan_idx_q;
        line_d       = line_q;
        slot_count_d = slot_count_q;
        test_vld_d   = 1'b0;
        obj_d        = obj_q;
        hit_y_d      = hit_y_q;
        xp_d         = xp_q;
        pmfa_d       = pmfa_q;
        hflip_d      = hflip_q;
        row_d        = row_q;
        obm_rd_o     = 1'b0;
        obm_addr_o   = 8'd0;
        slot_wr_o    = 1'b0;
`ifdef OBJ_SCHED_OVERFLOW_EN
        ovf_d        = ovf_q;
`endif
        case (state_q)
            ST_SCAN: begin
                if (test_vld_q && hit && !slots_full) begin
                    obm_rd_o   = 1'b1;
                    obm_addr_o = {test_obj, OBM_OFS_ATTR};
                    obj_d      = test_obj;
                    hit_y_d    = obm_data_i;
                    state_d    = ST_ATTR;
                end else if (more_y) begin
                    obm_rd_o   = 1'b1;
                    obm_addr_o = {scan_idx_q[5:0], OBM_OFS_Y};
                    scan_idx_d = scan_idx_q + 7'd1;
                    test_vld_d = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
`ifdef OBJ_SCHED_OVERFLOW_EN
                if (test_vld_q && hit && slots_full) begin
                    ovf_d = 1'b1;
                end
`endif
            end
            ST_ATTR: begin
                obm_rd_o   = 1'b1;
                obm_addr_o = {obj_q, OBM_OFS_X};
                hflip_d    = obm_data_i[6];
                pmfa_d     = obm_data_i[4:0];
                row_d      = row;
                state_d    = ST_XPOS;
            end
            ST_XPOS: begin
                obm_rd_o   = 1'b1;
                obm_addr_o = {obj_q, OBM_OFS_COLOR};
                xp_d       = obm_data_i;
                state_d    = ST_COLOR;
            end
            ST_COLOR: begin
                slot_wr_o    = 1'b1;
                slot_count_d = slot_count_q + 4'd1;
                if (more_y && !last_slot) begin
                    obm_rd_o   = 1'b1;
                    obm_addr_o = {scan_idx_q[5:0], OBM_OFS_Y};
                    scan_idx_d = scan_idx_q + 7'd1;
                    test_vld_d = 1'b1;
                    state_d    = ST_SCAN;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A start in any state (re)launches the scan; earlier slot writes go stale.
        if (start_i) begin
            state_d      = ST_SCAN;
            line_d       = next_y_i;
            slot_count_d = 4'd0;
            scan_idx_d   = 7'd0;
            test_vld_d   = 1'b0;
`ifdef OBJ_SCHED_OVERFLOW_EN
            ovf_d        = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            scan_idx_q   <= 7'd0;
            line_q       <= 8'd0;
            slot_count_q <= 4'd0;
            test_vld_q   <= 1'b0;
            obj_q        <= 6'd0;
            hit_y_q      <= 8'd0;
            xp_q         <= 8'd0;
            pmfa_q       <= 5'd0;
            hflip_q      <= 1'b0;
            row_q        <= 3'd0;
`ifdef OBJ_SCHED_OVERFLOW_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            scan_idx_q   <= scan_idx_d;
            line_q       <= line_d;
            slot_count_q <= slot_count_d;
            test_vld_q   <= test_vld_d;
            obj_q        <= obj_d;
            hit_y_q      <= hit_y_d;
            xp_q         <= xp_d;
            pmfa_q       <= pmfa_d;
            hflip_q      <= hflip_d;
            row_q        <= row_d;
`ifdef OBJ_SCHED_OVERFLOW_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign slot_idx_o   = slot_wr_o ? slot_count_q[2:0] : 3'd0;
    assign slot_xp_o    = slot_wr_o ? xp_q : 8'd0;
    assign slot_pmfa_o  = slot_wr_o ? pmfa_q : 5'd0;
    assign slot_hflip_o = slot_wr_o & hflip_q;
    assign slot_row_o   = slot_wr_o ? row_q : 3'd0;
    assign slot_color_o = slot_wr_o ? obm_data_i[2:0] : 3'd0;
    assign slot_count_o = slot_count_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_obj_line_scheduler.sv
// ============================================================================
// Module      : tb_obj_line_scheduler
// Description : Self-checking bench: scenario table plus slot-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_obj_line_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] next_y = 8'd0;
    logic       obm_rd;
    logic [7:0] obm_addr;
    logic [7:0] obm_data = 8'd0;
    logic       slot_wr;
    logic [2:0] slot_idx;
    logic [7:0] slot_xp;
    logic [4:0] slot_pmfa;
    logic       slot_hflip;
    logic [2:0] slot_row;
    logic [2:0] slot_color;
    logic [3:0] slot_count;
    logic       busy;
    logic       done;
    logic       overflow;

    obj_line_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .next_y_i     (next_y),
        .obm_rd_o     (obm_rd),
        .obm_addr_o   (obm_addr),
        .obm_data_i   (obm_data),
        .slot_wr_o    (slot_wr),
        .slot_idx_o   (slot_idx),
        .slot_xp_o    (slot_xp),
        .slot_pmfa_o  (slot_pmfa),
        .slot_hflip_o (slot_hflip),
        .slot_row_o   (slot_row),
        .slot_color_o (slot_color),
        .slot_count_o (slot_count),
        .busy_o       (busy),
        .done_o       (done),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];

    always @(posedge clk) begin
        if (obm_rd) obm_data <= mem[obm_addr];
    end

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] xp;
        logic [4:0] pmfa;
        logic       hflip;
        logic [2:0] row;
        logic [2:0] color;
    } slot_t;

    typedef struct {
        int    off;
        slot_t s;
    } exp_t;

    typedef struct {
        int         mode;
        logic [7:0] line;
        int         n_slots;
        int         done_off;
        logic       ovf;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[6];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   s_cyc = 0;
    int   exp_done_off = 0;
    int   exp_n = 0;
    logic exp_ovf = 1'b0;
    bit   done_seen = 1'b0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle c is observed at the c-th falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (slot_wr) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_slot_wr: got idx %0d at cycle S+%0d expected none",
                             slot_idx, cyc - s_cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("slot_fields", 32'({slot_idx, slot_xp, slot_pmfa, slot_hflip, slot_row, slot_color}),
                        32'(mon_e.s));
                    chk("slot_wr_cycle", 32'(cyc - s_cyc), 32'(mon_e.off));
                end
            end
            if (done) begin
                done_seen = 1'b1;
                done_cnt++;
                chk("done_cycle", 32'(cyc - s_cyc), 32'(exp_done_off));
                chk("done_slot_count", 32'(slot_count), 32'(exp_n));
                chk("done_overflow", 32'(overflow), 32'(exp_ovf));
                chk("obm_rd_in_done", 32'(obm_rd), 32'd0);
            end
        end
    end

    task automatic setup(input int mode);
        for (int k = 0; k < 64; k++) begin
            mem[4*k+0] = 8'(k);
            mem[4*k+1] = 8'((k * 13) & 8'h7f);
            mem[4*k+2] = 8'd200;
            mem[4*k+3] = 8'(k * 5 + 1);
        end
        case (mode)
            1: begin mem[22] = 8'd8; mem[23] = 8'd40; mem[21] = 8'h43; mem[20] = 8'd5; end
            2: begin mem[30] = 8'd252; mem[31] = 8'd99; mem[29] = 8'h2A; mem[28] = 8'd3; end
            3: for (int k = 0; k < 10; k++) mem[4*k+2] = 8'd0;
            4: begin mem[2] = 8'd3; mem[4*62+2] = 8'd10; mem[4*63+2] = 8'd2; end
            5: mem[4*63+2] = 8'd45;
            default: ;
        endcase
    endtask

    task automatic model(input logic [7:0] line);
        int cnt = 0;
        for (int k = 0; k < 64; k++) begin
            logic [7:0] d;
            logic [7:0] fl;
            exp_t e;
            d = line - mem[4*k+2];
            if (d < 8'd8 && cnt < 8) begin
                fl          = mem[4*k+1];
                e.off       = 5 + k + 3 * cnt;
                e.s.idx     = 3'(cnt);
                e.s.xp      = mem[4*k+3];
                e.s.pmfa    = fl[4:0];
                e.s.hflip   = fl[6];
                e.s.row     = fl[5] ? (3'd7 - d[2:0]) : d[2:0];
                e.s.color   = mem[4*k][2:0];
                exp_q.push_back(e);
                cnt++;
            end
        end
    endtask

    task automatic pulse_start(input logic [7:0] y);
        @(posedge clk); #2;
        start     = 1'b1;
        next_y    = y;
        s_cyc     = cyc + 1;
        done_seen = 1'b0;
        done_cnt  = 0;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done_seen && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_done_seen"}, 32'(done_seen), 32'd1);
        repeat (3) @(posedge clk);
        chk({name, "_done_once"}, 32'(done_cnt), 32'd1);
        chk({name, "_slots_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        setup(v.mode);
        exp_q.delete();
        exp_n        = v.n_slots;
        exp_done_off = v.done_off;
        exp_ovf      = v.ovf;
        model(v.line);
        pulse_start(v.line);
        wait_done(name);
    endtask

    initial begin
        vecs[0] = '{0, 8'd10, 0, 66, 1'b0};
        vecs[1] = '{1, 8'd10, 1, 69, 1'b0};
        vecs[2] = '{2, 8'd1,  1, 69, 1'b0};
`ifdef OBJ_SCHED_OVERFLOW_EN
        vecs[3] = '{3, 8'd3,  8, 90, 1'b1};
`else
        vecs[3] = '{3, 8'd3,  8, 34, 1'b0};
`endif
        vecs[4] = '{4, 8'd10, 2, 72, 1'b0};
        vecs[5] = '{5, 8'd50, 1, 69, 1'b0};

        setup(0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({busy, done, obm_rd, obm_addr, slot_wr, slot_count, overflow}), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Restart at S+20 with a new line: only the second scan completes.
        setup(3);
        exp_q.delete();
        pulse_start(8'd100);
        repeat (18) @(posedge clk);
        exp_n        = vecs[3].n_slots;
        exp_done_off = vecs[3].done_off;
        exp_ovf      = vecs[3].ovf;
        model(8'd3);
        pulse_start(8'd3);
        #1;
        chk("restart_y0_rd", 32'(obm_rd), 32'd1);
        chk("restart_y0_addr", 32'(obm_addr), 32'd2);
        chk("restart_count", 32'(slot_count), 32'd0);
        wait_done("restart");

        // Asynchronous reset while the attribute read of object 5 is outstanding.
        setup(1);
        exp_q.delete();
        model(8'd10);
        pulse_start(8'd10);
        repeat (7) @(posedge clk);
        #2;
        chk("attr_addr", 32'(obm_addr), 32'd23);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs",
            32'({busy, done, obm_rd, obm_addr, slot_wr, slot_count, overflow}), 32'd0);
        exp_q.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        chk("no_done_after_reset", 32'(done_cnt), 32'd0);
        run_vec(vecs[1], "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
